// File: rtl/iq_allocator_if.sv
// Dispatch/retire handshake bundle between the reorder buffer and the slot allocator.
// Ports: alloc_req*/retire* from the master (reorder buffer side); grants, indices,
//        oldest pointers and occupancy status from the slave (allocator).
`ifndef NUM_IQ_ENTRIES_LOG2
`define NUM_IQ_ENTRIES_LOG2 3
`endif

interface iq_allocator_if #(
    parameter int ADDR_WIDTH = `NUM_IQ_ENTRIES_LOG2
);
    logic                  alloc_req0;
    logic                  alloc_req1;
    logic                  alloc_grant0;
    logic                  alloc_grant1;
    logic [ADDR_WIDTH-1:0] alloc_index0;
    logic [ADDR_WIDTH-1:0] alloc_index1;
    logic                  retire0;
    logic                  retire1;
    logic [ADDR_WIDTH-1:0] oldest0;
    logic [ADDR_WIDTH-1:0] oldest1;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;

    modport master (
        output alloc_req0, alloc_req1, retire0, retire1,
        input  alloc_grant0, alloc_grant1, alloc_index0, alloc_index1,
        input  oldest0, oldest1, count, empty, full
    );

    modport slave (
        input  alloc_req0, alloc_req1, retire0, retire1,
        output alloc_grant0, alloc_grant1, alloc_index0, alloc_index1,
        output oldest0, oldest1, count, empty, full
    );
endinterface

// File: rtl/iq_allocator.sv
// In-order circular slot allocator / head tracker for the reorder buffer (2 alloc + 2 retire per cycle).
// Latency: grants and indices are combinational off registered count/tail; pointers update at posedge.
// Backpressure: grants drop when free space is short (partial grant possible); retires clamp to occupancy.
// Ports: clk, reset (sync, active-high), flush (sync, same state effect as reset), bus (iq_allocator_if.slave),
//        alloc_stall_count (32b, present only when IQ_ALLOC_STALL_STATS_EN is defined).
`ifndef NUM_IQ_ENTRIES_LOG2
`define NUM_IQ_ENTRIES_LOG2 3
`endif

module iq_allocator #(
    parameter int ADDR_WIDTH = `NUM_IQ_ENTRIES_LOG2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    iq_allocator_if.slave  bus
`ifdef IQ_ALLOC_STALL_STATS_EN
    ,
    output logic [31:0]    alloc_stall_count
`endif
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] TWO_C   = (ADDR_WIDTH+1)'(2);

    logic [ADDR_WIDTH-1:0] head_q;
    logic [ADDR_WIDTH-1:0] tail_q;
    logic [ADDR_WIDTH:0]   count_q;

    logic                  clr;
    logic [ADDR_WIDTH:0]   free;
    logic                  grant0;
    logic                  grant1;
    logic [1:0]            ret_raw;
    logic [1:0]            ret_n;
    logic [1:0]            grant_n;

    assign clr  = reset | flush;
    // Space is judged on the registered count only: a retire in this cycle frees nothing until next cycle.
    assign free = DEPTH_C - count_q;

    assign grant0 = ~clr & bus.alloc_req0 & (free >= ONE_C);
    assign grant1 = ~clr & bus.alloc_req0 & bus.alloc_req1 & (free >= TWO_C);

    // retire1 only counts alongside retire0; then clamp to what is actually in flight.
    always_comb begin
        ret_raw = {1'b0, bus.retire0} + {1'b0, bus.retire0 & bus.retire1};
        ret_n   = ret_raw;
        if (clr || count_q == '0) begin
            ret_n = 2'd0;
        end else if (count_q == ONE_C && ret_raw == 2'd2) begin
            ret_n = 2'd1;
        end
    end

    assign grant_n = {1'b0, grant0} + {1'b0, grant1};

    always_ff @(posedge clk) begin
        if (clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + ADDR_WIDTH'(ret_n);
            tail_q  <= tail_q + ADDR_WIDTH'(grant_n);
            count_q <= count_q + (ADDR_WIDTH+1)'(grant_n) - (ADDR_WIDTH+1)'(ret_n);
        end
    end

    assign bus.alloc_grant0 = grant0;
    assign bus.alloc_grant1 = grant1;
    assign bus.alloc_index0 = tail_q;
    assign bus.alloc_index1 = tail_q + ADDR_WIDTH'(1);
    assign bus.oldest0      = head_q;
    assign bus.oldest1      = head_q + ADDR_WIDTH'(1);
    assign bus.count        = count_q;
    assign bus.empty        = (count_q == '0);
    assign bus.full         = (count_q == DEPTH_C);

`ifdef IQ_ALLOC_STALL_STATS_EN
    logic        stall_evt;
    logic [31:0] stall_q;

    assign stall_evt = (bus.alloc_req0 & ~grant0) | (bus.alloc_req0 & bus.alloc_req1 & ~grant1);

    // Survives flush so the statistic spans pipeline flushes; saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!flush && stall_evt && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign alloc_stall_count = stall_q;
`endif
endmodule

// File: tb/tb_iq_allocator.sv
// Self-checking bench for iq_allocator (ADDR_WIDTH=3): vector table plus hand-written wrap/clamp sequence.
// Each applied vector pushes its expected outputs to a scoreboard queue; the sample step pops and compares.
`timescale 1ns/1ps

module tb_iq_allocator;
    typedef struct packed {
        logic       rst;
        logic       fl;
        logic       rq0;
        logic       rq1;
        logic       rt0;
        logic       rt1;
        logic       g0;
        logic       g1;
        logic [2:0] i0;
        logic [2:0] i1;
        logic [2:0] o0;
        logic [2:0] o1;
        logic [3:0] cnt;
        logic       em;
        logic       fu;
    } vec_t;

    logic clk;
    logic reset;
    logic flush;

    iq_allocator_if #(.ADDR_WIDTH(3)) bus ();

`ifdef IQ_ALLOC_STALL_STATS_EN
    logic [31:0] alloc_stall_count;
    logic [31:0] exp_stall;
`endif

    iq_allocator #(.ADDR_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
`ifdef IQ_ALLOC_STALL_STATS_EN
        ,
        .alloc_stall_count (alloc_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk;
    int   n_fail;
    int   step;
    vec_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit fl, bit rq0, bit rq1, bit rt0, bit rt1,
                                bit g0, bit g1, int i0, int i1, int o0, int o1, int cnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.rq0 = rq0; v.rq1 = rq1; v.rt0 = rt0; v.rt1 = rt1;
        v.g0  = g0;  v.g1 = g1;
        v.i0  = 3'(i0); v.i1 = 3'(i1); v.o0 = 3'(o0); v.o1 = 3'(o1);
        v.cnt = 4'(cnt);
        v.em  = (cnt == 0);
        v.fu  = (cnt == 8);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step%0d %s: got %0h expected %0h", step, name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, sample mid-cycle (combinational grants + registered state), advance.
    task automatic apply(vec_t v);
        vec_t e;
        reset          = v.rst;
        flush          = v.fl;
        bus.alloc_req0 = v.rq0;
        bus.alloc_req1 = v.rq1;
        bus.retire0    = v.rt0;
        bus.retire1    = v.rt1;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk("grants",  {30'd0, bus.alloc_grant0, bus.alloc_grant1}, {30'd0, e.g0, e.g1});
        chk("index0",  {29'd0, bus.alloc_index0}, {29'd0, e.i0});
        chk("index1",  {29'd0, bus.alloc_index1}, {29'd0, e.i1});
        chk("oldest0", {29'd0, bus.oldest0},      {29'd0, e.o0});
        chk("oldest1", {29'd0, bus.oldest1},      {29'd0, e.o1});
        chk("count",   {28'd0, bus.count},        {28'd0, e.cnt});
        chk("empty_full", {30'd0, bus.empty, bus.full}, {30'd0, e.em, e.fu});
`ifdef IQ_ALLOC_STALL_STATS_EN
        chk("stall_count", alloc_stall_count, exp_stall);
        if (e.rst) exp_stall = 32'd0;
        else if (!e.fl && ((e.rq0 && !e.g0) || (e.rq0 && e.rq1 && !e.g1))) exp_stall = exp_stall + 32'd1;
`endif
        step++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        step   = 0;
`ifdef IQ_ALLOC_STALL_STATS_EN
        exp_stall = 32'd0;
`endif
        reset = 1'b1; flush = 1'b0;
        bus.alloc_req0 = 1'b0; bus.alloc_req1 = 1'b0;
        bus.retire0 = 1'b0; bus.retire1 = 1'b0;
        @(posedge clk);
        #1;

        //             rst fl rq0 rq1 rt0 rt1  g0 g1  i0 i1  o0 o1  cnt
        tbl.push_back(mk(1, 0, 1, 1, 1, 1,   0, 0,  0, 1,  0, 1,  0)); // reset: grants forced 0
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0,  0, 1,  0, 1,  0)); // idle after reset
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  0, 1,  0, 1,  0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  2, 3,  0, 1,  2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  4, 5,  0, 1,  4));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  6, 7,  0, 1,  6));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   0, 0,  0, 1,  0, 1,  8)); // full: no grants
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,   0, 0,  0, 1,  0, 1,  8));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,   0, 0,  0, 1,  2, 3,  6));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,   0, 0,  0, 1,  4, 5,  4));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  0, 1,  6, 7,  2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  2, 3,  6, 7,  4));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  4, 5,  6, 7,  6));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1,   0, 0,  6, 7,  6, 7,  8)); // full, head 6: retire frees nothing yet
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  6, 7,  0, 1,  6)); // head wrapped to 0
        tbl.push_back(mk(0, 0, 0, 0, 1, 0,   0, 0,  0, 1,  0, 1,  8));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 0,  0, 1,  1, 2,  7)); // partial grant
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,   0, 0,  1, 2,  1, 2,  8));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,   0, 0,  1, 2,  3, 4,  6));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,   0, 0,  1, 2,  5, 6,  4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0,   0, 0,  1, 2,  7, 0,  2)); // oldest1 wraps
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,   0, 0,  1, 2,  0, 1,  1)); // count 1: retire1 clamped
        tbl.push_back(mk(0, 0, 0, 0, 1, 0,   0, 0,  1, 2,  1, 2,  0)); // count 0: retire ignored
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,   1, 0,  1, 2,  1, 2,  0)); // still unchanged; single alloc
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  2, 3,  1, 2,  1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,   0, 0,  4, 5,  1, 2,  3)); // req1/retire1 alone ignored
        tbl.push_back(mk(0, 0, 1, 1, 1, 0,   1, 1,  4, 5,  1, 2,  3)); // alloc + retire together
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0,  6, 7,  2, 3,  4));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0,   0, 0,  7, 0,  2, 3,  5)); // flush at head2 tail7 count5
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0,  0, 1,  0, 1,  0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  0, 1,  0, 1,  0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  2, 3,  0, 1,  2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1,  4, 5,  0, 1,  4));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,   1, 0,  6, 7,  0, 1,  6));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   1, 0,  7, 0,  0, 1,  7)); // count 7, tail 7: grant0 only
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0,  0, 1,  0, 1,  8)); // tail wrapped to 0
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0,  0, 1,  0, 1,  8)); // stalled at full
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0,  0, 1,  0, 1,  8));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,   0, 0,  0, 1,  0, 1,  8)); // reset while full
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0,  0, 1,  0, 1,  0));

        foreach (tbl[k]) apply(tbl[k]);

        // Drain to head 7 through the count==1 clamp, then alloc+retire at empty.
        apply(mk(0, 0, 1, 1, 0, 0,   1, 1,  0, 1,  0, 1,  0));
        apply(mk(0, 0, 1, 1, 0, 0,   1, 1,  2, 3,  0, 1,  2));
        apply(mk(0, 0, 1, 1, 0, 0,   1, 1,  4, 5,  0, 1,  4));
        apply(mk(0, 0, 1, 0, 0, 0,   1, 0,  6, 7,  0, 1,  6));
        apply(mk(0, 0, 0, 0, 1, 1,   0, 0,  7, 0,  0, 1,  7));
        apply(mk(0, 0, 0, 0, 1, 1,   0, 0,  7, 0,  2, 3,  5));
        apply(mk(0, 0, 0, 0, 1, 1,   0, 0,  7, 0,  4, 5,  3));
        apply(mk(0, 0, 0, 0, 1, 1,   0, 0,  7, 0,  6, 7,  1));
        apply(mk(0, 0, 0, 0, 0, 0,   0, 0,  7, 0,  7, 0,  0));
        apply(mk(0, 0, 1, 1, 1, 1,   1, 1,  7, 0,  7, 0,  0));
        apply(mk(0, 0, 0, 0, 0, 0,   0, 0,  1, 2,  7, 0,  2));

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
